// File: rtl/alu_simd_add_pipe_pkg.sv
// rtl/alu_simd_add_pipe_pkg.sv - lane-width encoding and lane geometry helpers for the SIMD adder
package alu_simd_add_pipe_pkg;

  typedef enum logic [1:0] {
    W64 = 2'd0,
    W32 = 2'd1,
    W16 = 2'd2,
    W8  = 2'd3
  } op_width_e;

  function automatic int lane_bits(op_width_e w);
    case (w)
      W64:     return 64;
      W32:     return 32;
      W16:     return 16;
      default: return 8;
    endcase
  endfunction

  // 1 when byte_idx is the least-significant byte of a lane, i.e. a carry boundary
  function automatic logic lane_start(op_width_e w, int byte_idx);
    return (byte_idx % (lane_bits(w) / 8)) == 0;
  endfunction

endpackage

// File: rtl/alu_simd_add_pipe_cla.sv
// rtl/alu_simd_add_pipe_cla.sv - combinational segmented carry-lookahead adder over DATA_W bits
module alu_simd_cla
  import alu_simd_add_pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  localparam int NB = DATA_W / 8
) (
  input  logic [DATA_W-1:0] p_i,
  input  logic [DATA_W-1:0] g_i,
  input  logic [NB-1:0]     cin_i,
  input  op_width_e         op_width_i,
  output logic [DATA_W-1:0] sum_o,
  output logic [NB-1:0]     cout_o
);

  logic [NB-1:0] grp_g;
  logic [NB-1:0] grp_p;
  logic [NB-1:0] byte_cin;
  logic          c;
  logic          cb;

  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int i = 0; i < NB; i++) begin
      grp_g[i] = 1'b0;
      grp_p[i] = 1'b1;
      for (int k = 0; k < 8; k++) begin
        grp_g[i] = g_i[8*i+k] | (p_i[8*i+k] & grp_g[i]);
        grp_p[i] = grp_p[i] & p_i[8*i+k];
      end
    end
  end

  // Byte-level lookahead: at a lane boundary the incoming group carry is killed and replaced by cin
  always_comb begin
    byte_cin = '0;
    cout_o   = '0;
    c        = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (lane_start(op_width_i, i)) c = cin_i[i];
      byte_cin[i] = c;
      c = grp_g[i] | (grp_p[i] & c);
      cout_o[i] = c;
    end
  end

  always_comb begin
    sum_o = '0;
    cb    = 1'b0;
    for (int i = 0; i < NB; i++) begin
      cb = byte_cin[i];
      for (int k = 0; k < 8; k++) begin
        sum_o[8*i+k] = p_i[8*i+k] ^ cb;
        cb = g_i[8*i+k] | (p_i[8*i+k] & cb);
      end
    end
  end

endmodule

// File: rtl/alu_simd_add_pipe.sv
// rtl/alu_simd_add_pipe.sv - two-stage SIMD add/sub with lane carry chaining; ALU_ADD_SAT_EN adds signed saturation
module alu_simd_add_pipe
  import alu_simd_add_pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  localparam int NB = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [1:0]        op_width_i,
  input  logic              sub_i,
  input  logic              chain_i,
  input  logic              sat_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] s_o,
  output logic [NB-1:0]     c_o,
  output logic [NB-1:0]     ovf_o
);

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] p_q, p_d, g_q, g_d;
  op_width_e         width_q, width_d;
  logic              chain_q, chain_d, sub_q, sub_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic [NB-1:0]     c_q, c_d, ovf_q, ovf_d, carry_q, carry_d;
`ifdef ALU_ADD_SAT_EN
  logic              sat_q, sat_d;
`else
  logic              unused_sat;
  assign unused_sat = sat_i;
`endif

  logic              s2_adv, in_ready, accept, load_s2;
  logic [DATA_W-1:0] b_eff, sum, res;
  logic [NB-1:0]     cin, cout, lane_c, lane_ovf;
  int                lb, msb_byte;

  always_comb begin
    s2_adv   = !out_valid_q || out_ready_i;
    in_ready = (!s1_valid_q || s2_adv) && !flush_i;
    accept   = in_valid_i && in_ready;
    load_s2  = s1_valid_q && s2_adv && !flush_i;
    b_eff    = sub_i ? ~b_i : b_i;
    for (int i = 0; i < NB; i++) cin[i] = chain_q ? carry_q[i] : sub_q;
  end

  alu_simd_cla #(.DATA_W(DATA_W)) u_cla (
    .p_i        (p_q),
    .g_i        (g_q),
    .cin_i      (cin),
    .op_width_i (width_q),
    .sum_o      (sum),
    .cout_o     (cout)
  );

  // p == 0 at the MSB means a and b' share a sign, and g then holds that sign
  always_comb begin
    lane_c   = '0;
    lane_ovf = '0;
    res      = sum;
    lb       = lane_bits(width_q) / 8;
    msb_byte = 0;
    for (int i = 0; i < NB; i++) begin
      msb_byte    = i | (lb - 1);
      lane_c[i]   = cout[msb_byte];
      lane_ovf[i] = !p_q[8*msb_byte+7] && (sum[8*msb_byte+7] != g_q[8*msb_byte+7]);
`ifdef ALU_ADD_SAT_EN
      if (sat_q && !chain_q && lane_ovf[i]) begin
        if (msb_byte == i) res[8*i +: 8] = g_q[8*msb_byte+7] ? 8'h80 : 8'h7F;
        else               res[8*i +: 8] = g_q[8*msb_byte+7] ? 8'h00 : 8'hFF;
      end
`endif
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    p_d         = p_q;
    g_d         = g_q;
    width_d     = width_q;
    chain_d     = chain_q;
    sub_d       = sub_q;
    out_valid_d = out_valid_q;
    s_d         = s_q;
    c_d         = c_q;
    ovf_d       = ovf_q;
    carry_d     = carry_q;
`ifdef ALU_ADD_SAT_EN
    sat_d       = sat_q;
`endif
    if (flush_i) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      carry_d     = '0;
    end else begin
      if (load_s2) begin
        out_valid_d = 1'b1;
        s_d         = res;
        c_d         = lane_c;
        ovf_d       = lane_ovf;
        carry_d     = lane_c;
      end else if (s2_adv) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        s1_valid_d = 1'b1;
        p_d        = a_i ^ b_eff;
        g_d        = a_i & b_eff;
        width_d    = op_width_e'(op_width_i);
        chain_d    = chain_i;
        sub_d      = sub_i;
`ifdef ALU_ADD_SAT_EN
        sat_d      = sat_i;
`endif
      end else if (s2_adv) begin
        s1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q  <= 1'b0;
      p_q         <= '0;
      g_q         <= '0;
      width_q     <= W64;
      chain_q     <= 1'b0;
      sub_q       <= 1'b0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      c_q         <= '0;
      ovf_q       <= '0;
      carry_q     <= '0;
`ifdef ALU_ADD_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      p_q         <= p_d;
      g_q         <= g_d;
      width_q     <= width_d;
      chain_q     <= chain_d;
      sub_q       <= sub_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      c_q         <= c_d;
      ovf_q       <= ovf_d;
      carry_q     <= carry_d;
`ifdef ALU_ADD_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid_q;
  assign s_o         = s_q;
  assign c_o         = c_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_alu_simd_add_pipe.sv
// tb/tb_alu_simd_add_pipe.sv - directed table-driven bench for alu_simd_add_pipe at DATA_W=64
module tb_alu_simd_add_pipe;

  localparam int DW = 64;
  localparam int NV = 14;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  w;
    logic        sub;
    logic        chain;
    logic        sat;
    logic [63:0] s;
    logic [7:0]  c;
    logic [7:0]  ovf;
  } vec_t;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] a_i = '0;
  logic [DW-1:0] b_i = '0;
  logic [1:0]    op_width_i = 2'd0;
  logic          sub_i = 1'b0;
  logic          chain_i = 1'b0;
  logic          sat_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [DW-1:0] s_o;
  logic [7:0]    c_o;
  logic [7:0]    ovf_o;

  vec_t vec [NV];
  int   n_cmp = 0;
  int   n_err = 0;
  int   idx, got, cyc, acc;

  alu_simd_add_pipe #(.DATA_W(DW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .op_width_i  (op_width_i),
    .sub_i       (sub_i),
    .chain_i     (chain_i),
    .sat_i       (sat_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .s_o         (s_o),
    .c_o         (c_o),
    .ovf_o       (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(logic [63:0] a, logic [63:0] b, logic [1:0] w, logic sub,
                              logic chain, logic sat, logic [63:0] s, logic [7:0] c, logic [7:0] ovf);
    vec_t v;
    v.a = a; v.b = b; v.w = w; v.sub = sub; v.chain = chain; v.sat = sat;
    v.s = s; v.c = c; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int i);
    a_i = vec[i].a; b_i = vec[i].b; op_width_i = vec[i].w;
    sub_i = vec[i].sub; chain_i = vec[i].chain; sat_i = vec[i].sat;
  endtask

  task automatic check_out(input int i);
    chk($sformatf("v%0d_s", i), s_o, vec[i].s);
    chk($sformatf("v%0d_c", i), {56'd0, c_o}, {56'd0, vec[i].c});
    chk($sformatf("v%0d_ovf", i), {56'd0, ovf_o}, {56'd0, vec[i].ovf});
  endtask

  // Offers vec[idx..hi-1] and checks results vec[got..hi-1] in order, one beat per cycle max
  task automatic run_stream(input int hi);
    cyc = 0;
    while (got < hi && cyc < 300) begin
      @(negedge clk_i);
      cyc++;
      if (out_valid_o && out_ready_i) begin
        check_out(got);
        got++;
      end
      if (idx < hi) begin
        drive(idx);
        in_valid_i = 1'b1;
      end else begin
        in_valid_i = 1'b0;
      end
      #1;
      if (in_valid_i && in_ready_o) idx++;
    end
    in_valid_i = 1'b0;
    if (got < hi) chk("stream_timeout", 64'(got), 64'(hi));
    @(negedge clk_i);
  endtask

  initial begin
    vec[0]  = mk(64'h01FF_7F80_00FF_0102, 64'h0101_0180_0101_0101, 2'd3, 0, 0, 0,
                 64'h0200_8000_0100_0203, 8'h54, 8'h30);
    vec[1]  = mk(64'hFFFF_FFFF_0000_0001, 64'h0000_0001_FFFF_FFFF, 2'd1, 0, 0, 0,
                 64'h0, 8'hFF, 8'h00);
    vec[2]  = mk(64'h0000_8000_0005_0003, 64'h0001_0001_0003_0005, 2'd2, 1, 0, 0,
                 64'hFFFF_7FFF_0002_FFFE, 8'h3C, 8'h30);
    vec[3]  = mk(64'h0, 64'h1, 2'd0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 8'h00);
    vec[4]  = mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'd0, 0, 0, 0,
                 64'h0, 8'hFF, 8'hFF);
    vec[5]  = mk(64'h0, 64'h0, 2'd0, 0, 1, 0, 64'h1, 8'h00, 8'h00);
`ifdef ALU_ADD_SAT_EN
    vec[6]  = mk(64'h7FFF_7FFF_7FFF_7FFF, 64'h0001_0001_0001_0001, 2'd2, 0, 0, 1,
                 64'h7FFF_7FFF_7FFF_7FFF, 8'h00, 8'hFF);
`else
    vec[6]  = mk(64'h7FFF_7FFF_7FFF_7FFF, 64'h0001_0001_0001_0001, 2'd2, 0, 0, 1,
                 64'h8000_8000_8000_8000, 8'h00, 8'hFF);
`endif
    vec[7]  = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'd0, 0, 0, 0, 64'h0, 8'hFF, 8'h00);
    vec[8]  = mk(64'h0, 64'h0, 2'd3, 0, 1, 0, 64'h0101_0101_0101_0101, 8'h00, 8'h00);
    vec[9]  = mk(64'h1111_1111_1111_1111, 64'h0101_0101_0101_0101, 2'd3, 0, 0, 0,
                 64'h1212_1212_1212_1212, 8'h00, 8'h00);
    vec[10] = mk(64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080, 2'd1, 0, 0, 0,
                 64'h0101_0100_0101_0100, 8'hFF, 8'hFF);
    vec[11] = mk(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 2'd0, 0, 0, 0,
                 64'h1234_5678_9ABC_DF00, 8'h00, 8'h00);
    vec[12] = mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'd0, 0, 0, 0,
                 64'h0, 8'hFF, 8'hFF);
    vec[13] = mk(64'h0, 64'h0, 2'd0, 0, 1, 0, 64'h0, 8'h00, 8'h00);

    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
    chk("rst_s", s_o, 64'd0);
    chk("rst_c", {56'd0, c_o}, 64'd0);
    chk("rst_ovf", {56'd0, ovf_o}, 64'd0);

    drive(3);
    in_valid_i = 1'b1;
    #1 chk("lat_accept", {63'd0, in_ready_o}, 64'd1);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    chk("lat_cycle1_valid", {63'd0, out_valid_o}, 64'd0);
    @(negedge clk_i);
    chk("lat_cycle2_valid", {63'd0, out_valid_o}, 64'd1);
    check_out(3);
    @(negedge clk_i);

    idx = 0; got = 0;
    run_stream(9);

    out_ready_i = 1'b0;
    idx = 9; acc = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      if (k >= 3) chk("stall_hold_s", s_o, vec[9].s);
      if (idx < 12) begin
        drive(idx);
        in_valid_i = 1'b1;
      end
      #1;
      if (in_valid_i && in_ready_o) begin
        idx++;
        acc++;
      end
    end
    chk("stall_accepted", 64'(acc), 64'd2);
    chk("stall_in_ready", {63'd0, in_ready_o}, 64'd0);
    chk("stall_out_valid", {63'd0, out_valid_o}, 64'd1);
    check_out(9);
    got = 10;
    out_ready_i = 1'b1;
    #1;
    if (in_valid_i && in_ready_o) idx++;
    run_stream(12);

    out_ready_i = 1'b0;
    drive(12);
    in_valid_i = 1'b1;
    @(negedge clk_i);
    drive(12);
    @(negedge clk_i);
    flush_i = 1'b1;
    drive(9);
    #1 chk("flush_in_ready", {63'd0, in_ready_o}, 64'd0);
    @(negedge clk_i);
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid_o}, 64'd0);
    out_ready_i = 1'b1;
    idx = 13; got = 13;
    run_stream(14);

    drive(9);
    in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk("midrst_out_valid", {63'd0, out_valid_o}, 64'd0);
    end
    chk("midrst_s", s_o, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
